multicycle_control: RTL and testbench
=====================================

# multicycle_control

Sequential successor to the single-cycle main decoder: a Moore state machine that sequences each RISC-V instruction (lw, sw, R-type, I-type ALU, beq, jal) over multiple cycles. It drives the shared-memory multicycle datapath and supports variable-latency memory through a ready handshake. An optional wait-state timeout and sticky illegal-opcode trap are included. It sits between the instruction register and the datapath muxes/enables; the ALU decoder consumes `alu_op` unchanged.

## Interface
- `TIMEOUT_CYCLES`, 0: max consecutive wait cycles in a memory state; 0 disables the timeout.
- `EN_JAL`, 1: 1 decodes jal (1101111); 0 treats it as illegal.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 7: instr[6:0] from the instruction register, valid from DECODE onward.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access requested (FETCH, MEMREAD, MEMWRITE).
- `mem_write` out 1: write request; held until accepted.
- `adr_src` out 1: 0=PC, 1=ALU result.
- `ir_write` out 1: load the instruction register.
- `pc_write` out 1: `pc_update | (branch & zero)`.
- `reg_write` out 1: register-file write.
- `result_src` out 2: 00 ALUOut, 01 mem data, 10 ALU result.
- `alu_src_a` out 2: 00 PC, 01 OldPC, 10 rs1.
- `alu_src_b` out 2: 00 rs2, 01 imm, 10 const 4.
- `alu_op` out 2: 00 add, 01 sub/branch, 10 R-type, 11 I-type.
- `illegal` out 1: sticky; set on an unsupported opcode in DECODE.
- `timeout` out 1: sticky; set on a wait-state overrun.
- `state` out 4: current state, for debug/trace.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
- FETCH:
  - Outputs: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10.
  - ir_write=1 and pc_update=1 only in the cycle mem_ready=1; that cycle advances to DECODE, otherwise stay.
- DECODE: a=01, b=01, alu_op=00 (branch target). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL (if EN_JAL)
  - anything else → TRAP, setting `illegal`.
- MEMADR: a=10, b=01, alu_op=00. Next is MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Leaves to MEMWB when mem_ready=1.
- MEMWB: result_src=01, reg_write=1. Next FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Leaves to FETCH when mem_ready=1.
- EXECR: a=10, b=00, alu_op=10. Next ALUWB.
- EXECI: a=10, b=01, alu_op=11. Next ALUWB.
- ALUWB: result_src=00, reg_write=1. Next FETCH.
- BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1. Next FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1. Next ALUWB.
- TRAP: all enables 0. Absorbing; exited only by reset.
- Timeout (TIMEOUT_CYCLES>0): a wait counter counts consecutive mem_ready=0 cycles in FETCH, MEMREAD and MEMWRITE.
  - It clears on any state change.
  - When the count reaches TIMEOUT_CYCLES with mem_ready still 0, next state is TRAP and `timeout` is set.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Every output not listed for a state is 0.

## Timing
- Reset (async assert, sync-deasserted by the environment):
  - state=FETCH; illegal=0, timeout=0, wait counter=0.
  - All outputs take FETCH decode: mem_req=1, all write enables 0 until mem_ready.
- Outputs are combinational from state, gated by mem_ready only where stated. No registered output latency.
- Cycle counts with mem_ready tied 1:

| Instruction | Cycles |
|---|---|
| lw | 5 |
| sw | 4 |
| R-type | 4 |
| I-type | 4 |
| beq | 3 |
| jal | 4 |

- Each wait cycle adds exactly 1.
- mem_ready=1 in a non-memory state is ignored.
- Reset mid-instruction: the next cycle after rst_n rises is FETCH; no partial write enables are produced.
- Simultaneous mem_ready=1 and count==TIMEOUT_CYCLES: completion wins, no trap.

## Structure
- `ctrl_pkg` holds:
  - the state enum (4-bit, typedef `ctrl_state_t`)
  - opcode localparams (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BEQ, OP_JAL)
  - alu_op, result_src, alu_src_a/b encodings.
- Sub-module `wait_timer`: counter + overrun flag, parametrised by TIMEOUT_CYCLES. Instantiated only when TIMEOUT_CYCLES>0 (generate).
- Next-state and output logic are separate always_comb blocks; the state register is always_ff.

## Test plan
- R-type add, mem_ready=1 → state sequence FETCH, DECODE, EXECR, ALUWB, FETCH. reg_write=1 only in cycle 4, with result_src=00.
- lw, mem_ready low for 3 cycles in MEMREAD → exactly 8 cycles total; reg_write in MEMWB with result_src=01.
- beq with zero=1 → pc_write=1 in the BEQ cycle. Repeat with zero=0 → pc_write=0. Both take 3 cycles.
- sw with mem_ready=0 for 2 cycles → mem_write stays high for 3 cycles, then FETCH.
- Opcode 1110011 → TRAP after DECODE; illegal=1 holds for 20 cycles. rst_n pulse → FETCH, illegal=0.
- TIMEOUT_CYCLES=4, mem_ready=0 in FETCH → TRAP after 4 wait cycles, timeout=1. Separately, mem_ready=1 on the 4th wait cycle → DECODE, no trap.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller.
// State enum, opcodes and datapath mux/ALU select encodings.
package ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10,
    StTrap     = 4'd11
  } ctrl_state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_R   = 2'b10;
  localparam logic [1:0] ALU_OP_I   = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle.
// master = controller side, slave = datapath side.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_write;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op
  );
endinterface

// File: rtl/wait_timer.sv
// Counts consecutive not-ready cycles in a memory state; flags an overrun
// when the limit is reached and memory is still not ready.
module wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic mem_ready,
  input  logic clear,
  output logic overrun
);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Completion in the same cycle as the limit wins over the overrun.
  assign overrun = active && !mem_ready && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (active && !mem_ready && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing RISC-V lw/sw/R/I/beq/jal over the multicycle datapath,
// with ready-handshaked memory, optional wait timeout and sticky traps.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter bit          EN_JAL         = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_control_if.master   bus,
  output logic                   illegal,
  output logic                   timeout,
  output logic [3:0]             state
);
  ctrl_state_t state_q, state_d;
  logic        illegal_q, illegal_d;
  logic        timeout_q, timeout_d;
  logic        overrun;
  logic        pc_update, branch;

  if (TIMEOUT_CYCLES > 0) begin : g_timer
    logic in_wait;
    assign in_wait = (state_q == StFetch) || (state_q == StMemRead) ||
                     (state_q == StMemWrite);
    wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .active   (in_wait),
      .mem_ready(bus.mem_ready),
      .clear    (state_d != state_q),
      .overrun  (overrun)
    );
  end else begin : g_no_timer
    assign overrun = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StFetch, StMemRead, StMemWrite: begin
        if (bus.mem_ready) begin
          state_d = (state_q == StFetch)   ? StDecode :
                    (state_q == StMemRead) ? StMemWb  : StFetch;
        end else if (overrun) begin
          state_d   = StTrap;
          timeout_d = 1'b1;
        end
      end
      StDecode: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = StMemAdr;
          OP_R:              state_d = StExecR;
          OP_I:              state_d = StExecI;
          OP_BEQ:            state_d = StBeq;
          OP_JAL: begin
            state_d   = EN_JAL ? StJal : StTrap;
            illegal_d = illegal_q | !EN_JAL;
          end
          default: begin
            state_d   = StTrap;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAdr:                state_d = (bus.opcode == OP_STORE) ? StMemWrite : StMemRead;
      StExecR, StExecI, StJal: state_d = StAluWb;
      StMemWb, StAluWb, StBeq: state_d = StFetch;
      StTrap:                  state_d = StTrap;
      default:                 state_d = StFetch;
    endcase
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.adr_src    = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.result_src = RES_ALUOUT;
    bus.alu_src_a  = SRC_A_PC;
    bus.alu_src_b  = SRC_B_RS2;
    bus.alu_op     = ALU_OP_ADD;
    pc_update      = 1'b0;
    branch         = 1'b0;
    unique case (state_q)
      StFetch: begin
        bus.mem_req    = 1'b1;
        bus.alu_src_b  = SRC_B_FOUR;
        bus.result_src = RES_ALU;
        bus.ir_write   = bus.mem_ready;
        pc_update      = bus.mem_ready;
      end
      StDecode: begin
        bus.alu_src_a = SRC_A_OLDPC;
        bus.alu_src_b = SRC_B_IMM;
      end
      StMemAdr: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_IMM;
      end
      StMemRead: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
      end
      StMemWb: begin
        bus.result_src = RES_MEM;
        bus.reg_write  = 1'b1;
      end
      StMemWrite: begin
        bus.mem_req   = 1'b1;
        bus.mem_write = 1'b1;
        bus.adr_src   = 1'b1;
      end
      StExecR: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_op    = ALU_OP_R;
      end
      StExecI: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_IMM;
        bus.alu_op    = ALU_OP_I;
      end
      StAluWb: bus.reg_write = 1'b1;
      StBeq: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_op    = ALU_OP_SUB;
        branch        = 1'b1;
      end
      StJal: begin
        bus.alu_src_a = SRC_A_OLDPC;
        bus.alu_src_b = SRC_B_FOUR;
        pc_update     = 1'b1;
      end
      default: ;
    endcase
    bus.pc_write = pc_update | (branch & bus.zero);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign state   = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Randomised bench: each instruction is expanded into its step schedule and every
// cycle's state and outputs are compared against the expected step behaviour.
module tb_multicycle_control;
  import ctrl_pkg::*;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       illegal, timeout;
  logic [3:0] state;
  int         n_cmp = 0;
  int         n_mis = 0;
  logic       m_ill = 1'b0;
  logic       m_to  = 1'b0;

  multicycle_control_if bus ();

  multicycle_control #(
    .TIMEOUT_CYCLES(TO),
    .EN_JAL        (1'b1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .illegal(illegal),
    .timeout(timeout),
    .state  (state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [15:0] obs_outs();
    return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
            bus.reg_write, bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
            illegal, timeout};
  endfunction

  // Expected outputs of each step, straight from the step table.
  function automatic logic [15:0] exp_outs(ctrl_state_t s, logic rdy, logic z);
    logic mreq = 0, mw = 0, adr = 0, irw = 0, pcw = 0, rw = 0;
    logic [1:0] rs = 2'b00, a = 2'b00, b = 2'b00, op = 2'b00;
    case (s)
      StFetch:    begin mreq = 1; b = 2; rs = 2; irw = rdy; pcw = rdy; end
      StDecode:   begin a = 1; b = 1; end
      StMemAdr:   begin a = 2; b = 1; end
      StMemRead:  begin mreq = 1; adr = 1; end
      StMemWb:    begin rs = 1; rw = 1; end
      StMemWrite: begin mreq = 1; mw = 1; adr = 1; end
      StExecR:    begin a = 2; op = 2; end
      StExecI:    begin a = 2; b = 1; op = 3; end
      StAluWb:    rw = 1;
      StBeq:      begin a = 2; op = 1; pcw = z; end
      StJal:      begin a = 1; b = 2; pcw = 1; end
      default:    ;
    endcase
    return {mreq, mw, adr, irw, pcw, rw, rs, a, b, op, m_ill, m_to};
  endfunction

  task automatic one_cycle(input ctrl_state_t s, input logic rdy);
    bus.mem_ready = rdy;
    bus.zero      = 1'($urandom % 2);
    #1;
    check_val($sformatf("state_%s", s.name()), 32'(state), 32'(s));
    check_val($sformatf("outs_%s", s.name()), 32'(obs_outs()),
              32'(exp_outs(s, rdy, bus.zero)));
    @(posedge clk);
    #1;
  endtask

  function automatic int pick_wait();
    int r = int'($urandom_range(0, 99));
    if (r < 60) return 0;
    if (r < 90) return int'($urandom_range(1, 3));
    if (r < 96) return TO;
    return TO + 1;
  endfunction

  // Memory step: w not-ready cycles then ready; TO+1 or more overruns to trap.
  task automatic mem_step(input ctrl_state_t s, input int w, output bit trapped);
    int wv = (w < 0) ? pick_wait() : w;
    trapped = 1'b0;
    for (int k = 0; k <= TO; k++) begin
      one_cycle(s, k == wv);
      if (k == wv) break;
      if (k == TO) begin
        m_to    = 1'b1;
        trapped = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    bus.mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    m_ill = 1'b0;
    m_to  = 1'b0;
    check_val("rst_state", 32'(state), 32'(StFetch));
    check_val("rst_outs", 32'(obs_outs()), 32'(exp_outs(StFetch, 1'b0, bus.zero)));
    @(posedge clk);
    #1;
    check_val("rst_hold_state", 32'(state), 32'(StFetch));
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [6:0] op, input int w_fetch, input int w_mem,
                           input int hold);
    ctrl_state_t sched[$];
    bit trapped;
    bus.opcode = op;
    case (op)
      OP_LOAD:  sched = '{StMemAdr, StMemRead, StMemWb};
      OP_STORE: sched = '{StMemAdr, StMemWrite};
      OP_R:     sched = '{StExecR, StAluWb};
      OP_I:     sched = '{StExecI, StAluWb};
      OP_BEQ:   sched = '{StBeq};
      OP_JAL:   sched = '{StJal, StAluWb};
      default:  sched = {};
    endcase
    mem_step(StFetch, w_fetch, trapped);
    if (!trapped) begin
      one_cycle(StDecode, 1'($urandom % 2));
      if (sched.size() == 0) begin
        m_ill   = 1'b1;
        trapped = 1'b1;
      end
      foreach (sched[i]) begin
        if (sched[i] == StMemRead || sched[i] == StMemWrite) begin
          mem_step(sched[i], w_mem, trapped);
          if (trapped) break;
        end else begin
          one_cycle(sched[i], 1'($urandom % 2));
        end
      end
    end
    if (trapped) begin
      repeat (hold) one_cycle(StTrap, 1'($urandom % 2));
      do_reset();
    end
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] op;
    case ($urandom_range(0, 13))
      0, 1:    return OP_LOAD;
      2, 3:    return OP_STORE;
      4, 5:    return OP_R;
      6, 7:    return OP_I;
      8, 9:    return OP_BEQ;
      10, 11:  return OP_JAL;
      default: begin
        op = 7'($urandom);
        if (op == OP_LOAD || op == OP_STORE || op == OP_R || op == OP_I ||
            op == OP_BEQ || op == OP_JAL) op = 7'b1110011;
        return op;
      end
    endcase
  endfunction

  initial begin
    bus.opcode    = OP_R;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    do_reset();
    run_instr(OP_R, 0, 0, 0);
    run_instr(OP_LOAD, 0, 3, 0);
    run_instr(OP_BEQ, 0, 0, 0);
    run_instr(OP_BEQ, 0, 0, 0);
    run_instr(OP_STORE, 0, 2, 0);
    run_instr(OP_JAL, 1, 0, 0);
    run_instr(7'b1110011, 0, 0, 20);
    run_instr(OP_R, TO + 1, 0, 3);
    run_instr(OP_R, TO, 0, 0);
    run_instr(OP_LOAD, 0, TO + 1, 3);
    run_instr(OP_STORE, 0, TO, 0);
    repeat (300) run_instr(rand_op(), -1, -1, int'($urandom_range(2, 6)));
    // Reset while in MEMREAD of a load.
    bus.opcode = OP_LOAD;
    one_cycle(StFetch, 1'b1);
    one_cycle(StDecode, 1'b0);
    one_cycle(StMemAdr, 1'b1);
    do_reset();
    run_instr(OP_I, 0, 0, 0);
    one_cycle(StFetch, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
